// File: rtl/chacha_pkg.sv
// Shared types, sizes and helpers for the ChaCha keystream engine.
// Holds the FSM encoding, block geometry, rotation amounts and the parameter legality check.
package chacha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COPY,
        ST_CALC,
        ST_SUM,
        ST_DONE
    } state_t;

    localparam int BLOCK_BITS      = 512;
    localparam int WORDS           = 16;
    localparam int STEPS_PER_ROUND = 8;

    // Counter word 12 sits at this bit offset; word 13 follows directly above it.
    localparam int CTR_LSB = 384;

    localparam int ROT_A = 16;
    localparam int ROT_B = 12;
    localparam int ROT_C = 8;
    localparam int ROT_D = 7;

    function automatic bit params_ok(input int rounds, input int data_w);
        return (rounds % 2 == 0) && (rounds >= 8) && (rounds <= 20) &&
               ((data_w == 8) || (data_w == 16) || (data_w == 32));
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_keystream_if.sv
// Host-side bus of the keystream engine: chunked state load, commands and block readout.
// The host (master) drives data_in and commands; the engine (slave) returns data_out/ready/busy.
interface chacha_keystream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              write;
    logic              start;
    logic              next;
    logic              read;
    logic [DATA_W-1:0] data_out;
    logic              ready;
    logic              busy;

    modport master (
        output data_in, write, start, next, read,
        input  data_out, ready, busy
    );

    modport slave (
        input  data_in, write, start, next, read,
        output data_out, ready, busy
    );
endinterface

// File: rtl/chacha_qr.sv
// Combinational half of a ChaCha quarter-round; sel=0 uses rotations 16/12, sel=1 uses 8/7.
// Zero latency, no flow control.
module chacha_qr
    import chacha_pkg::*;
(
    input  logic        sel,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out
);
    logic [31:0] a1;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] c1;
    logic [31:0] b1;

    always_comb begin
        a1    = a_in + b_in;
        d1    = d_in ^ a1;
        d2    = sel ? rotl32(d1, ROT_C) : rotl32(d1, ROT_A);
        c1    = c_in + d2;
        b1    = b_in ^ c1;
        a_out = a1;
        c_out = c1;
        d_out = d2;
        b_out = sel ? rotl32(b1, ROT_D) : rotl32(b1, ROT_B);
    end

endmodule

// File: rtl/chacha_keystream.sv
// ChaCha block engine: one half-quarter-round per cycle, ready ROUNDS*8+3 cycles after start/next.
// Commands arriving while busy are dropped; write aborts any computation and always shifts in.
module chacha_keystream
    import chacha_pkg::*;
#(
    parameter int ROUNDS     = 20,
    parameter int DATA_W     = 8,
    parameter int COUNTER_64 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    chacha_keystream_if.slave bus
);
    localparam int STEPS  = ROUNDS * STEPS_PER_ROUND;
    localparam int STEP_W = $clog2(STEPS);
    localparam int CHUNKS = BLOCK_BITS / DATA_W;
    localparam int PTR_W  = $clog2(CHUNKS);

    if (!params_ok(ROUNDS, DATA_W)) begin : g_bad_params
        $error("chacha_keystream: ROUNDS must be even in 8..20 and DATA_W one of 8/16/32");
    end

    state_t                state;
    state_t                state_d;
    logic [STEP_W-1:0]     step;
    logic [PTR_W-1:0]      rd_ptr;
    logic [BLOCK_BITS-1:0] in_state;
    logic [BLOCK_BITS-1:0] out_buf;
    logic [31:0]           work [WORDS];

    logic cmd_ok;
    logic inc_ctr;
    logic rd_adv;
    logic busy_w;
    logic ready_w;

    assign busy_w  = (state == ST_COPY) || (state == ST_CALC) || (state == ST_SUM);
    assign ready_w = (state == ST_DONE);
    assign cmd_ok  = !bus.write && (bus.start || bus.next) &&
                     ((state == ST_IDLE) || (state == ST_DONE));
    // start outranks next, so a simultaneous pair computes without bumping the counter.
    assign inc_ctr = cmd_ok && !bus.start;
    assign rd_adv  = ready_w && bus.read && !bus.write && !bus.start && !bus.next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (bus.write) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (cmd_ok) state_d = ST_COPY;
                ST_COPY:          state_d = ST_CALC;
                ST_CALC:          if (step == STEP_W'(STEPS - 1)) state_d = ST_SUM;
                ST_SUM:           state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Step bits: [0] selects the half, [2:1] the quarter-round, [3] column vs diagonal round.
    logic       half;
    logic       diag;
    logic [1:0] k;
    logic [1:0] kb;
    logic [1:0] kc;
    logic [1:0] kd;
    logic [3:0] ia;
    logic [3:0] ib;
    logic [3:0] ic;
    logic [3:0] id;

    assign half = step[0];
    assign k    = step[2:1];
    assign diag = step[3];
    assign kb   = k + {1'b0, diag};
    assign kc   = k + {diag, 1'b0};
    assign kd   = k + {diag, diag};
    assign ia   = {2'b00, k};
    assign ib   = {2'b01, kb};
    assign ic   = {2'b10, kc};
    assign id   = {2'b11, kd};

    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] qc;
    logic [31:0] qd;

    chacha_qr u_qr (
        .sel   (half),
        .a_in  (work[ia]),
        .b_in  (work[ib]),
        .c_in  (work[ic]),
        .d_in  (work[id]),
        .a_out (qa),
        .b_out (qb),
        .c_out (qc),
        .d_out (qd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step     <= '0;
            rd_ptr   <= '0;
            in_state <= '0;
            out_buf  <= '0;
            for (int i = 0; i < WORDS; i++) begin
                work[i] <= '0;
            end
        end else begin
            if (bus.write) begin
                in_state <= {bus.data_in, in_state[BLOCK_BITS-1:DATA_W]};
            end else if (inc_ctr) begin
                if (COUNTER_64 != 0) begin
                    in_state[CTR_LSB +: 64] <= in_state[CTR_LSB +: 64] + 64'd1;
                end else begin
                    in_state[CTR_LSB +: 32] <= in_state[CTR_LSB +: 32] + 32'd1;
                end
            end

            if (bus.write || cmd_ok) begin
                rd_ptr <= '0;
            end else if (rd_adv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if ((state == ST_CALC) && (state_d == ST_CALC)) begin
                step <= step + 1'b1;
            end else begin
                step <= '0;
            end

            case (state)
                ST_COPY: begin
                    for (int i = 0; i < WORDS; i++) begin
                        work[i] <= in_state[32*i +: 32];
                    end
                end
                ST_CALC: begin
                    work[ia] <= qa;
                    work[ib] <= qb;
                    work[ic] <= qc;
                    work[id] <= qd;
                end
                ST_SUM: begin
                    for (int i = 0; i < WORDS; i++) begin
                        out_buf[32*i +: 32] <= work[i] + in_state[32*i +: 32];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = ready_w;
    assign bus.busy     = busy_w;
    assign bus.data_out = ready_w ? out_buf[rd_ptr*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_chacha_keystream.sv
// Directed bench for chacha_keystream across round counts, bus widths and counter modes.
module tb_chacha_keystream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    chacha_keystream_if #(.DATA_W(8))  if0 ();
    chacha_keystream_if #(.DATA_W(32)) if1 ();
    chacha_keystream_if #(.DATA_W(32)) if2 ();
    chacha_keystream_if #(.DATA_W(16)) if3 ();
    chacha_keystream_if #(.DATA_W(16)) if4 ();

    chacha_keystream #(.ROUNDS(20), .DATA_W(8),  .COUNTER_64(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    chacha_keystream #(.ROUNDS(20), .DATA_W(32), .COUNTER_64(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    chacha_keystream #(.ROUNDS(20), .DATA_W(32), .COUNTER_64(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    chacha_keystream #(.ROUNDS(8),  .DATA_W(16), .COUNTER_64(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    chacha_keystream #(.ROUNDS(12), .DATA_W(16), .COUNTER_64(0)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    // Reference ChaCha block, written as plain column/diagonal double rounds.
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] model_block(input logic [511:0] st, input int rounds);
        logic [31:0]  x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
        for (int i = 0; i < rounds / 2; i++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + st[32*i +: 32];
        return r;
    endfunction

    function automatic int dw_of(input int which);
        case (which)
            0:       return 8;
            1, 2:    return 32;
            default: return 16;
        endcase
    endfunction

    function automatic logic [31:0] dout(input int which);
        case (which)
            0:       return {24'h0, if0.data_out};
            1:       return if1.data_out;
            2:       return if2.data_out;
            3:       return {16'h0, if3.data_out};
            default: return {16'h0, if4.data_out};
        endcase
    endfunction

    function automatic logic rdy(input int which);
        case (which)
            0:       return if0.ready;
            1:       return if1.ready;
            2:       return if2.ready;
            3:       return if3.ready;
            default: return if4.ready;
        endcase
    endfunction

    function automatic logic bsy(input int which);
        case (which)
            0:       return if0.busy;
            1:       return if1.busy;
            2:       return if2.busy;
            3:       return if3.busy;
            default: return if4.busy;
        endcase
    endfunction

    task automatic drive(input int which, input logic w, input logic s, input logic n,
                         input logic r, input logic [31:0] d);
        case (which)
            0: begin if0.write = w; if0.start = s; if0.next = n; if0.read = r; if0.data_in = d[7:0];  end
            1: begin if1.write = w; if1.start = s; if1.next = n; if1.read = r; if1.data_in = d;       end
            2: begin if2.write = w; if2.start = s; if2.next = n; if2.read = r; if2.data_in = d;       end
            3: begin if3.write = w; if3.start = s; if3.next = n; if3.read = r; if3.data_in = d[15:0]; end
            default: begin if4.write = w; if4.start = s; if4.next = n; if4.read = r; if4.data_in = d[15:0]; end
        endcase
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int which, input logic [511:0] st);
        int dw;
        dw = dw_of(which);
        for (int j = 0; j < 512 / dw; j++) begin
            drive(which, 1'b1, 1'b0, 1'b0, 1'b0, 32'(st >> (j * dw)));
            tick;
        end
        drive(which, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic cmd(input int which, input logic s, input logic n);
        drive(which, 1'b0, s, n, 1'b0, 32'h0);
        tick;
        drive(which, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Entered one cycle after the command was sampled; optional pokes of read/start while busy.
    task automatic wait_ready(input int which, input string tag, input int exp_lat,
                              input int rd_at, input int st_at);
        int n;
        n = 0;
        while (!rdy(which) && n < 400) begin
            drive(which, 1'b0, (n == st_at), 1'b0, (n == rd_at), 32'h0);
            tick;
            n++;
        end
        drive(which, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check(tag, 512'(n + 1), 512'(exp_lat));
    endtask

    task automatic read_block(input int which, output logic [511:0] blk);
        int dw;
        dw = dw_of(which);
        blk = '0;
        for (int j = 0; j < 512 / dw; j++) begin
            blk = blk | (512'(dout(which)) << (j * dw));
            drive(which, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            tick;
        end
        drive(which, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    logic [511:0] rfc_st;
    logic [511:0] a1_st;
    logic [511:0] wrap_st;
    logic [511:0] exp_st;
    logic [511:0] blk;

    initial begin
        rfc_st = {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
                  32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                  32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
                  32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        a1_st   = {384'h0, rfc_st[127:0]};
        wrap_st = rfc_st;
        wrap_st[415:384] = 32'hffffffff;
        wrap_st[447:416] = 32'h12345678;

        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) drive(i, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick; tick;
        check("reset_ready", 512'(rdy(0)), 512'(0));
        check("reset_busy", 512'(bsy(0)), 512'(0));
        check("reset_data_out", 512'(dout(0)), 512'(0));
        rst_n = 1'b1;
        tick;

        // RFC 8439 2.3.2, byte-wide bus; a read while busy must not move the pointer,
        // and a start during CALC must not change the latency.
        load(0, rfc_st);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick;
        check("idle_read_data_out", 512'(dout(0)), 512'(0));
        cmd(0, 1'b1, 1'b0);
        check("busy_after_start", 512'(bsy(0)), 512'(1));
        wait_ready(0, "latency_r20", 163, 10, 20);
        check("rfc_first_byte", 512'(dout(0)), 512'(8'h10));
        read_block(0, blk);
        check("rfc_word0", 512'(blk[31:0]), 512'(32'he4e7f110));
        check("rfc_block", blk, model_block(rfc_st, 20));
        check("read_wrap_65th", 512'(dout(0)), 512'(8'h10));

        cmd(0, 1'b1, 1'b0);
        check("ready_drop_on_restart", 512'(rdy(0)), 512'(0));
        wait_ready(0, "latency_restart", 163, -1, -1);

        cmd(0, 1'b1, 1'b0);
        for (int i = 0; i < 51; i++) tick;
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("abort_busy", 512'(bsy(0)), 512'(0));
        check("abort_ready", 512'(rdy(0)), 512'(0));

        // RFC 8439 A.1 test vectors 1 and 2 on a 32-bit bus.
        load(1, a1_st);
        cmd(1, 1'b1, 1'b0);
        wait_ready(1, "a1_latency", 163, -1, -1);
        check("a1_1_word0", 512'(dout(1)), 512'(32'hade0b876));
        cmd(1, 1'b0, 1'b1);
        wait_ready(1, "a1_next_latency", 163, -1, -1);
        check("a1_2_word0", 512'(dout(1)), 512'(32'hbee7079f));

        // 32-bit counter wraps into word12 only, and the bumped value persists.
        load(1, wrap_st);
        cmd(1, 1'b0, 1'b1);
        wait_ready(1, "wrap32_latency", 163, -1, -1);
        read_block(1, blk);
        exp_st = wrap_st;
        exp_st[415:384] = 32'h0;
        check("wrap32_block", blk, model_block(exp_st, 20));
        cmd(1, 1'b0, 1'b1);
        wait_ready(1, "wrap32_next2_latency", 163, -1, -1);
        read_block(1, blk);
        exp_st[415:384] = 32'h1;
        check("wrap32_retained", blk, model_block(exp_st, 20));

        // 64-bit counter carries into word13, then wraps fully at 2^64-1.
        load(2, wrap_st);
        cmd(2, 1'b0, 1'b1);
        wait_ready(2, "wrap64_latency", 163, -1, -1);
        read_block(2, blk);
        exp_st = wrap_st;
        exp_st[415:384] = 32'h0;
        exp_st[447:416] = 32'h12345679;
        check("wrap64_carry_block", blk, model_block(exp_st, 20));
        exp_st = wrap_st;
        exp_st[447:384] = 64'hffffffff_ffffffff;
        load(2, exp_st);
        cmd(2, 1'b0, 1'b1);
        wait_ready(2, "wrap64_full_latency", 163, -1, -1);
        read_block(2, blk);
        exp_st[447:384] = 64'h0;
        check("wrap64_full_block", blk, model_block(exp_st, 20));

        // Reduced-round variants on a 16-bit bus.
        load(3, rfc_st);
        cmd(3, 1'b1, 1'b0);
        wait_ready(3, "latency_r8", 67, -1, -1);
        read_block(3, blk);
        check("r8_block", blk, model_block(rfc_st, 8));
        load(4, rfc_st);
        cmd(4, 1'b1, 1'b0);
        wait_ready(4, "latency_r12", 99, -1, -1);
        read_block(4, blk);
        check("r12_block", blk, model_block(rfc_st, 12));

        // Reset asserted mid-computation returns to idle without waiting for a clock.
        cmd(3, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) tick;
        check("busy_mid_calc", 512'(bsy(3)), 512'(1));
        rst_n = 1'b0;
        #1;
        check("reset_mid_calc_busy", 512'(bsy(3)), 512'(0));
        check("reset_mid_calc_ready", 512'(rdy(3)), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
